// File: rtl/spi_pkg.sv
// Shared types and sizing helper for the SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timebase: divides clk by CLK_DIV per half-period and counts half-periods while en.
// Latency: first toggle strobe CLK_DIV cycles after en rises.
// Backpressure: none; strobes are consumed unconditionally by the FSM.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 10,
  parameter int HW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          toggle,
  output logic          lead,
  output logic          trail,
  output logic          last,
  output logic [HW-1:0] half_cnt
);

  localparam int DW = width_for(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign toggle = en && (div_cnt == DW'(CLK_DIV - 1));
  assign lead   = toggle && !half_cnt[0];
  assign trail  = toggle && half_cnt[0];
  assign last   = toggle && (half_cnt == HW'(2 * DATA_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!en || toggle) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt <= '0;
    end else if (!en || last) begin
      half_cnt <= '0;
    end else if (toggle) begin
      half_cnt <= half_cnt + HW'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// SPI master: one word per start, selectable mode/order/CS, back-to-back bursts on one CS.
// Latency: 1 + CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD clk from accept to done.
// Backpressure: start is taken only while ready=1; otherwise it is dropped silently.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 10,
  parameter int NUM_CS   = 1,
  parameter int CS_SETUP = 10,
  parameter int CS_HOLD  = 10
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             cpol,
  input  logic                             cpha,
  input  logic                             lsb_first,
  input  logic [width_for(NUM_CS - 1)-1:0] cs_sel,
  input  logic [DATA_W-1:0]                tx_data,
  output logic                             ready,
  output logic                             done,
  output logic                             err,
  output logic [DATA_W-1:0]                rx_data,
  output logic                             sclk,
  output logic                             mosi,
  input  logic                             miso,
  output logic [NUM_CS-1:0]                cs_n
);

  localparam int CS_W    = width_for(NUM_CS - 1);
  localparam int IW      = width_for(DATA_W - 1);
  localparam int HW      = IW + 1;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD)
                         ? ((CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV)
                         : ((CS_HOLD > CLK_DIV) ? CS_HOLD : CLK_DIV);
  localparam int CW      = width_for(CNT_MAX);

  spi_state_t        state, state_nxt;
  spi_mode_t         mode_q;
  logic [CS_W-1:0]   cs_q;
  logic [DATA_W-1:0] tx_q, rx_sr;
  logic [CW-1:0]     cnt;
  logic              gap;
  logic              miso_s1, miso_s2;
  logic              toggle, lead, trail, last;
  logic [HW-1:0]     half_cnt;
  logic [IW-1:0]     bit_k;
  logic              cs_ok, hold_end, accept, sample_edge, shift_edge;

  function automatic logic [IW-1:0] bit_pos(input logic [IW-1:0] k, input logic lsb);
    return lsb ? k : IW'(DATA_W - 1) - k;
  endfunction

  spi_sclk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .HW      (HW)
  ) u_sclk_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (state == SHIFT),
    .toggle   (toggle),
    .lead     (lead),
    .trail    (trail),
    .last     (last),
    .half_cnt (half_cnt)
  );

  assign cs_ok       = 32'(cs_sel) < NUM_CS;
  assign hold_end    = (state == HOLD) && !gap && (cnt == CW'(CS_HOLD));
  // In the done cycle only a same-CS start continues the burst.
  assign accept      = start && ready && ((state == IDLE) ? cs_ok : (cs_sel == cs_q));
  assign bit_k       = half_cnt[HW-1:1];
  assign sample_edge = mode_q.cpha ? trail : lead;
  assign shift_edge  = mode_q.cpha ? lead : trail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (cnt == CW'(CS_SETUP - 1)) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = HOLD;
      HOLD: begin
        if (gap) begin
          if (cnt == CW'(CLK_DIV - 1)) state_nxt = SHIFT;
        end else if (hold_end && !accept) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      HOLD: begin
        ready = hold_end;
        done  = hold_end;
      end
      default: ready = 1'b0;
    endcase
    err = start && ready && !cs_ok;
  end

  // SETUP, HOLD and the inter-word gap all time off this one counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      gap <= 1'b0;
    end else begin
      if ((state_nxt != state) || accept) begin
        cnt <= '0;
      end else if ((state == SETUP) || (state == HOLD)) begin
        cnt <= cnt + CW'(1);
      end
      if (accept && (state == HOLD)) begin
        gap <= 1'b1;
      end else if (state_nxt == SHIFT) begin
        gap <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
      tx_q   <= '0;
      cs_q   <= '0;
      cs_n   <= '1;
      sclk   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
        tx_q   <= tx_data;
        cs_q   <= cs_sel;
        cs_n   <= ~(NUM_CS'(1) << cs_sel);
        sclk   <= cpol;
      end else begin
        if (hold_end) cs_n <= '1;
        if (toggle) begin
          sclk <= ~sclk;
        end else if (state == HOLD) begin
          sclk <= mode_q.cpol;
        end
      end
    end
  end

  // With cpha=0 the first bit must already be on mosi before the leading edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi <= 1'b0;
    end else if (accept) begin
      if (!cpha) mosi <= tx_data[bit_pos(IW'(0), lsb_first)];
    end else if (shift_edge) begin
      if (mode_q.cpha) begin
        mosi <= tx_q[bit_pos(bit_k, mode_q.lsb_first)];
      end else if (bit_k != IW'(DATA_W - 1)) begin
        mosi <= tx_q[bit_pos(bit_k + IW'(1), mode_q.lsb_first)];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
      rx_sr   <= '0;
      rx_data <= '0;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
      if (sample_edge) rx_sr[bit_pos(bit_k, mode_q.lsb_first)] <= miso_s2;
      if ((state == HOLD) && !gap && (cnt == CW'(CS_HOLD - 1))) rx_data <= rx_sr;
    end
  end

endmodule
